// File: rtl/alu_pkg.sv
// Shared types for the ALU and its sequential accumulator front-end.
package alu_pkg;

  localparam int unsigned ACC_DATA_WIDTH = 4;
  localparam int unsigned ALU_OP_W       = 2;
  localparam int unsigned ACC_CMD_W      = 2;
  localparam int unsigned ACC_STATE_W    = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  // Encoding 2'd3 is undefined and behaves as CMD_CLEAR.
  typedef enum logic [ACC_CMD_W-1:0] {
    CMD_LOAD  = 2'd0,
    CMD_EXEC  = 2'd1,
    CMD_CLEAR = 2'd2
  } acc_cmd_t;

  typedef enum logic [ACC_STATE_W-1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } acc_flags_t;

endpackage

// File: rtl/alu_acc_seq_if.sv
// Command and result handshakes between the accumulator and its neighbours.
interface alu_acc_seq_if #(
  parameter int unsigned DATA_WIDTH = alu_pkg::ACC_DATA_WIDTH
);
  import alu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  acc_cmd_t              in_cmd;
  alu_op_t               in_op;
  logic [DATA_WIDTH-1:0] in_operand;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_z;
  logic                  out_n;
  logic                  out_v;
  logic                  out_c;
  logic                  out_v_sticky;

  modport master (
    output in_valid, in_cmd, in_op, in_operand, out_ready,
    input  in_ready, out_valid, out_result, out_z, out_n, out_v, out_c, out_v_sticky
  );

  modport slave (
    input  in_valid, in_cmd, in_op, in_operand, out_ready,
    output in_ready, out_valid, out_result, out_z, out_n, out_v, out_c, out_v_sticky
  );

endinterface

// File: rtl/alu.sv
// Combinational signed ALU; carry is bit W of the sign-extended (W+1)-bit result.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  alu_op_t               op_i,
  output logic [DATA_WIDTH-1:0] res_c_o,
  output acc_flags_t            flags_c_o
);

  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [EW-1:0] a_x;
  logic [EW-1:0] b_x;
  logic [EW-1:0] ext;
  logic          v;
  logic          c;

  assign a_x = {a_i[DATA_WIDTH-1], a_i};
  assign b_x = {b_i[DATA_WIDTH-1], b_i};

  always_comb begin
    ext     = '0;
    res_c_o = '0;
    v       = 1'b0;
    c       = 1'b0;
    case (op_i)
      ALU_ADD: begin
        ext     = a_x + b_x;
        res_c_o = ext[DATA_WIDTH-1:0];
        v       = ext[DATA_WIDTH] ^ ext[DATA_WIDTH-1];
        c       = ext[DATA_WIDTH];
      end
      ALU_SUB: begin
        ext     = a_x - b_x;
        res_c_o = ext[DATA_WIDTH-1:0];
        v       = ext[DATA_WIDTH] ^ ext[DATA_WIDTH-1];
        c       = ext[DATA_WIDTH];
      end
      ALU_AND: res_c_o = a_i & b_i;
      default: res_c_o = a_i | b_i;
    endcase
  end

  assign flags_c_o = '{z: (res_c_o == '0), n: res_c_o[DATA_WIDTH-1], v: v, c: c};

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer: accepts LOAD/EXEC/CLEAR commands, writes back through the ALU,
// and holds the registered result until the consumer takes it.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH
) (
  input logic          clk,
  input logic          rst,
  alu_acc_seq_if.slave bus
);

  acc_state_t            state_q, state_d;
  acc_cmd_t              cmd_q;
  alu_op_t               op_q;
  logic [DATA_WIDTH-1:0] operand_q;

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  acc_flags_t            flags_q, flags_d;
  logic                  sticky_q, sticky_d;

  logic                  in_ready_c;
  logic                  latch_c;
  logic                  wb_c;

  logic [DATA_WIDTH-1:0] alu_res;
  acc_flags_t            alu_flags;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i      (acc_q),
    .b_i      (operand_q),
    .op_i     (op_q),
    .res_c_o  (alu_res),
    .flags_c_o(alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake control; DONE may hand straight over to EXEC.
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    latch_c    = 1'b0;
    wb_c       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          latch_c = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        wb_c    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            latch_c = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-back values per latched command.
  always_comb begin
    acc_d    = acc_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    if (wb_c) begin
      case (cmd_q)
        CMD_LOAD: begin
          acc_d    = operand_q;
          flags_d  = '{z: (operand_q == '0), n: operand_q[DATA_WIDTH-1], v: 1'b0, c: 1'b0};
          sticky_d = 1'b0;
        end
        CMD_EXEC: begin
          acc_d    = alu_res;
          flags_d  = alu_flags;
          sticky_d = sticky_q | alu_flags.v;
        end
        default: begin
          acc_d    = '0;
          flags_d  = '{z: 1'b1, n: 1'b0, v: 1'b0, c: 1'b0};
          sticky_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= CMD_CLEAR;
      op_q      <= ALU_ADD;
      operand_q <= '0;
    end else if (latch_c) begin
      cmd_q     <= bus.in_cmd;
      op_q      <= bus.in_op;
      operand_q <= bus.in_operand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready     = in_ready_c & ~rst;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_result   = acc_q;
  assign bus.out_z        = flags_q.z;
  assign bus.out_n        = flags_q.n;
  assign bus.out_v        = flags_q.v;
  assign bus.out_c        = flags_q.c;
  assign bus.out_v_sticky = sticky_q;

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Sequential accumulator front-end for the combinational `alu`. It accepts a stream of commands, each one operand plus an operation, over a valid/ready handshake. It feeds the ALU with the accumulator as operand `a` and the command operand as `b`, then writes back the ALU result into the accumulator. Registered result and flags are presented downstream over a second valid/ready handshake. It sits between the instruction/operand source and any result consumer, and owns the only copy of the accumulator and status register.

## Interface
- DATA_WIDTH, 4, operand/accumulator width in bits (signed two's complement)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  block can accept a command this cycle
- in_cmd  in  acc_cmd_t  CMD_LOAD, CMD_EXEC or CMD_CLEAR
- in_op  in  alu_op_t  ALU operation, used only for CMD_EXEC
- in_operand  in  DATA_WIDTH  signed operand
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- out_result  out  DATA_WIDTH  accumulator after the command
- out_z, out_n, out_v, out_c  out  1 each  flags of the command
- out_v_sticky  out  1  OR of all `v` since last LOAD/CLEAR

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch cmd/op/operand and go to EXEC.
- EXEC:
  - in_ready=0, out_valid=0.
  - The ALU is driven with a=acc, b=latched operand, op=latched op.
  - At the clock edge, write back per command and go to DONE.
- Write-back per command:
  - CMD_LOAD: acc<=operand; z,n from operand; v=c=0; sticky<=0.
  - CMD_EXEC: acc<=alu result; z,n,v,c<=alu flags; sticky<=sticky|v.
  - CMD_CLEAR: acc<=0; z=1, n=v=c=0; sticky<=0.
- DONE:
  - out_valid=1.
  - Outputs are held stable until out_ready.
  - in_ready=out_ready: a command may be accepted in the same cycle the result is taken, going straight to EXEC.
  - out_ready without in_valid goes to IDLE.
- Arithmetic: signed DATA_WIDTH wrap-around.
  - v = signed result outside [-(2^(W-1)), 2^(W-1)-1].
  - c = bit W of the (W+1)-bit sign-extended result.
  - v=c=0 for ALU_AND/ALU_OR.
- An undefined in_cmd encoding is treated as CMD_CLEAR.
- Reset values: acc=0, all flags 0, sticky 0, out_valid 0, out_result 0. in_ready=1 once rst deasserts.
- Reset in EXEC or DONE aborts the command. Its result is never presented.

## Timing
- Accept at edge N, then out_valid high after edge N+1. Latency is 2 edges; in_valid to out_valid is 2 cycles.
- Max throughput is one command per 2 cycles (back-to-back via DONE→EXEC).
- out_result and flags are registered and change only on the EXEC→DONE edge.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to any output.
- No input is sampled outside the accept cycle.

## Structure
- The existing `alu_pkg` gains:
  - `acc_cmd_t` (2-bit enum: CMD_LOAD, CMD_EXEC, CMD_CLEAR)
  - `acc_state_t` (IDLE, EXEC, DONE)
- `alu_op_t` is reused unchanged.
- One sub-module: `alu` (DATA_WIDTH passed through), instantiated as `u_alu`. There is no duplicate arithmetic in this block.

## Test plan
All values use DATA_WIDTH=4.
- Reset then idle → in_ready=1, out_valid=0, out_result=0, all flags 0.
- LOAD 5, then EXEC ALU_ADD 3 → second result 4'b1000 (-8), n=1, v=1, c=0, z=0, sticky=1.
- From acc=-8: EXEC ALU_SUB 1 → result 7, n=0, v=1, c=1. Then ALU_AND 0 → result 0, z=1, v=c=0, sticky still 1. Then CLEAR → result 0, z=1, sticky=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0. Raise out_ready with next command pending → accepted that cycle, next out_valid 2 cycles later.
- Assert rst during EXEC of ADD 2 (acc=3) → all outputs 0 immediately, no out_valid for the aborted command. The next LOAD 1 gives result 1.
- 200 random commands, checked against a scoreboard model of acc/flags and a latency check of exactly 2 cycles from accept to out_valid.
